tx_reg_pipe: RTL
================

TX_REG_PIPE -- requirements
Module: tx_reg_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data bits per word; SHALL be legal for any value >= 1.
REQ-002 Parameter STAGES, default 2: register stages between input and output; SHALL be legal for any value >= 1.
REQ-003 clk  input  1  single clock; every register SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 flush  input  1  synchronous discard of all words held in the pipeline.
REQ-006 in_valid  input  1  in_data carries a word this cycle.
REQ-007 in_data  input  WIDTH  word to transmit.
REQ-008 in_ready  output  1  pipeline accepts in_data this cycle.
REQ-009 out_valid  output  1  out_data carries a word this cycle.
REQ-010 out_data  output  WIDTH  word at the head of the pipeline.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 occupancy  output  $clog2(STAGES+1)  number of valid stages; present only when TX_REG_PIPE_CNT_EN is defined.

Function
REQ-013 Stages 0..STAGES-1 SHALL each hold one WIDTH-bit data register and one valid flag; stage 0 is the input side, stage STAGES-1 the output side.
REQ-014 out_data and out_valid SHALL be driven directly from the stage STAGES-1 registers, with no combinational path from in_data.
REQ-015 A transfer SHALL occur on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-016 Stage STAGES-1 SHALL advance when it is empty or out_ready=1; stage i<STAGES-1 SHALL advance when it is empty or stage i+1 advances.
REQ-017 in_ready SHALL equal (stage 0 advances) && !flush && !reset.
REQ-018 When a stage advances, it SHALL load data and valid from the previous stage (stage 0 loads in_data and in_valid && in_ready).
REQ-019 A stage that does not advance SHALL hold its data and valid unchanged.
REQ-020 Data registers SHALL load only when valid data is moving into them; a bubble moving in SHALL clear only the valid flag.
REQ-021 A word accepted in cycle N with out_ready held high SHALL appear with out_valid=1 in cycle N+STAGES; sustained throughput SHALL be one word per cycle.
REQ-022 Bubbles SHALL collapse: with out_ready low, new words SHALL be accepted until all STAGES stages are valid, then in_ready SHALL drop to 0.
REQ-023 Full pipeline with out_ready=1 and in_valid=1: one word out and one word in during the same cycle, with occupancy unchanged.
REQ-024 flush=1 SHALL clear every valid flag at the next edge and accept no input that cycle; any out_valid&&out_ready transfer in that cycle still counts as consumed. Data registers SHALL be left unchanged.
REQ-025 flush and reset asserted together SHALL behave as reset.
REQ-026 Word order SHALL be strictly preserved; no word may be duplicated or dropped except by flush or reset.

Reset
REQ-027 reset=1 SHALL clear every valid flag and data register to 0 at the next rising edge.
REQ-028 After that edge, out_valid=0, out_data=0, and occupancy=0 (if present).
REQ-029 While reset=1, in_ready=0 and no word SHALL be accepted or presented.
REQ-030 Reset asserted mid-stream SHALL discard all held words; the first word accepted after reset deasserts SHALL be the first word output.

Configuration
REQ-031 Macro TX_REG_PIPE_CNT_EN defined: the occupancy port SHALL exist and equal the count of set valid flags, registered and updated in the same edge as the flags (range 0..STAGES).
REQ-032 Macro TX_REG_PIPE_CNT_EN undefined: the occupancy port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 WIDTH=8, STAGES=2, out_ready=1, send 0xA5 then 0x3C in consecutive cycles -> out_data 0xA5 then 0x3C with out_valid=1, at 2 cycles latency each.
REQ-034 STAGES=3, out_ready=0, in_valid=1 for 5 cycles with 0x01..0x05 -> 0x01..0x03 accepted, in_ready=0 from cycle 3, occupancy=3; raise out_ready -> output 0x01,0x02,0x03,0x04,0x05 in order.
REQ-035 Full STAGES=2 pipeline, in_valid=1 and out_ready=1 held -> one word in and one out per cycle, occupancy stays 2.
REQ-036 Pipeline holding 0x11,0x22; flush=1 with in_valid=1, in_data=0x33 -> in_ready=0, next cycle out_valid=0, occupancy=0, and 0x33 never emitted.
REQ-037 reset=1 for one cycle mid-stream with WIDTH=16 -> out_valid=0, out_data=0x0000; next word accepted (0xBEEF) is the first word output.
REQ-038 Build without TX_REG_PIPE_CNT_EN, rerun REQ-033 -> identical out_data/out_valid trace, and occupancy port absent.

Source files
------------

// File: rtl/tx_reg_pipe.sv
// tx_reg_pipe: multi-stage valid/ready register pipeline for a transmit path.
// Each stage holds one data word and a valid flag. Bubbles collapse, so the
// pipe fills completely under backpressure and streams one word per cycle
// when the consumer is ready.
// Optional feature: define TX_REG_PIPE_CNT_EN to add the registered
// `occupancy` output (number of valid stages, 0..STAGES).
module tx_reg_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef TX_REG_PIPE_CNT_EN
    ,
    output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

    logic [WIDTH-1:0]  data_q  [STAGES];
    logic [STAGES-1:0] valid_q;

    logic [STAGES-1:0] advance;
    logic [STAGES-1:0] valid_in;
    logic [WIDTH-1:0]  data_in [STAGES];
    logic [STAGES-1:0] valid_next;

    // A stage advances when it or any stage downstream of it is empty, or the consumer takes the head word
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        advance  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            all_full   = all_full & valid_q[i];
            advance[i] = out_ready || !all_full;
        end
    end

    assign in_ready = advance[0] && !flush && !reset;

    // What each stage would load if it advances: stage 0 takes the accepted input, others take their predecessor
    always_comb begin
        valid_in    = '0;
        valid_in[0] = in_valid && in_ready;
        data_in[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
            valid_in[i] = valid_q[i-1];
            data_in[i]  = data_q[i-1];
        end
    end

    // Next valid flags: advancing stages take the incoming flag, stalled stages hold, flush empties everything
    always_comb begin
        valid_next = valid_q;
        for (int i = 0; i < STAGES; i++) begin
            if (advance[i]) begin
                valid_next[i] = valid_in[i];
            end
        end
        if (flush) begin
            valid_next = '0;
        end
    end

    // Stage registers: data only moves when a real word moves in, so bubbles and flushes leave data untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_next;
            for (int i = 0; i < STAGES; i++) begin
                if (advance[i] && valid_in[i] && !flush) begin
                    data_q[i] <= data_in[i];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

`ifdef TX_REG_PIPE_CNT_EN
    localparam int CW = $clog2(STAGES + 1);

    logic [CW-1:0] count_next;

    // Population count of the flags that will be valid after this edge
    always_comb begin
        count_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            count_next = count_next + CW'(valid_next[i]);
        end
    end

    // Occupancy register tracks the valid flags on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= count_next;
        end
    end
`endif

endmodule
